// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM state type and helpers for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    // ARM reads the PC as the address of the current instruction plus 8.
    localparam logic [31:0] PC_READ_OFFSET   = 32'd8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding
        ST_HOLD  = 2'd1,  // word parked in skid buffer while decode is stalled
        ST_DRAIN = 2'd2   // waiting out a stale in-flight word after a redirect
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not accept.
// Latency: load visible on the next edge; clear/unload empty it on the next edge.
// Backpressure: none internally; the fetch FSM only loads when the entry is free.
// Ports: clk/reset, load/clear/unload controls, word_in/pc_plus8_in data in,
//        word/pc_plus8/full state out.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        unload,
    input  logic [31:0] word_in,
    input  logic [31:0] pc_plus8_in,
    output logic [31:0] word,
    output logic [31:0] pc_plus8,
    output logic        full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= 32'h0;
            pc_plus8 <= 32'h0;
            full     <= 1'b0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            word     <= word_in;
            pc_plus8 <= pc_plus8_in;
            full     <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request handshake and IF/ID register.
// Latency: imem wait cycles + 1 edge from request to valid_d; 1 instr/cycle at zero wait.
// Backpressure: stall holds PC and IF/ID, an acked word parks in the skid buffer (HOLD).
// Ports: clk/reset; stall, flush_d, pc_src, branch_target from hazard/branch logic;
//        imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//        pc_f, inst_d, pc_plus8_d, valid_d to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_d,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] inst_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d
);

    fetch_state_t state;
    logic [31:0]  drain_addr;   // address of the stale request being waited out
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_plus8;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_unload;
    logic [31:0]  skid_word;
    logic [31:0]  skid_pc_plus8;
    logic         skid_full;

    assign pc_plus4  = pc_f + PC_STEP;
    assign pc_plus8  = pc_f + PC_READ_OFFSET;

    // The memory must see a stable address until it acks, so DRAIN keeps
    // presenting the pre-redirect address while the PC already moved on.
    assign imem_req  = (state != ST_HOLD);
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc_f;

    // A flush while holding (and not stalled) drops the parked word; the PC
    // still points at it, so returning to FETCH refetches it.
    always_comb begin
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        skid_unload = 1'b0;
        if (pc_src) begin
            skid_clear = 1'b1;
        end else if (flush_d) begin
            skid_clear = (state == ST_HOLD) && !stall;
        end else begin
            skid_load   = (state == ST_FETCH) && imem_ack && stall;
            skid_unload = (state == ST_HOLD) && !stall;
        end
    end

    fetch_skid_buffer u_skid (
        .clk         (clk),
        .reset       (reset),
        .load        (skid_load),
        .clear       (skid_clear),
        .unload      (skid_unload),
        .word_in     (imem_rdata),
        .pc_plus8_in (pc_plus8),
        .word        (skid_word),
        .pc_plus8    (skid_pc_plus8),
        .full        (skid_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc_f       <= RESET_PC;
            drain_addr <= RESET_PC;
            inst_d     <= NOP_INST;
            pc_plus8_d <= 32'h0;
            valid_d    <= 1'b0;
        end else if (pc_src) begin
            // Redirect beats stall and flush in every state.
            pc_f    <= word_align(branch_target);
            inst_d  <= NOP_INST;
            valid_d <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (!imem_ack) begin
                        state      <= ST_DRAIN;
                        drain_addr <= pc_f;
                    end
                end
                ST_DRAIN: state <= imem_ack ? ST_FETCH : ST_DRAIN;
                default:  state <= ST_FETCH;
            endcase
        end else if (flush_d) begin
            // Kill IF/ID; an acked word is not captured and the PC stays put.
            inst_d  <= NOP_INST;
            valid_d <= 1'b0;
            if ((state == ST_HOLD && !stall) || (state == ST_DRAIN && imem_ack)) begin
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (stall) begin
                            state <= ST_HOLD;
                        end else begin
                            pc_f       <= pc_plus4;
                            inst_d     <= imem_rdata;
                            pc_plus8_d <= pc_plus8;
                            valid_d    <= 1'b1;
                        end
                    end else if (!stall) begin
                        valid_d <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        inst_d     <= skid_word;
                        pc_plus8_d <= skid_pc_plus8;
                        valid_d    <= skid_full;
                        pc_f       <= pc_plus4;
                        state      <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table with a manual
// memory, then scoreboarded sequences against an auto-ack memory model.
// Ports: drives every DUT port; clk generated locally.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush_d;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] inst_d;
    logic [31:0] pc_plus8_d;
    logic        valid_d;

    logic        mem_auto;
    logic        ack_man;
    int          wait_n;
    int          wcnt;
    logic        sb_on;
    logic [31:0] sbq[$];
    int          total;
    int          bad;

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hE5A0_0000;
    endfunction

    // Memory model: auto mode acks after wait_n cycles of a held request.
    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    assign imem_ack   = mem_auto ? (imem_req && (wcnt >= wait_n)) : ack_man;
    assign imem_rdata = w(imem_addr);

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush_d       (flush_d),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_f          (pc_f),
        .inst_d        (inst_d),
        .pc_plus8_d    (pc_plus8_d),
        .valid_d       (valid_d)
    );

    typedef struct {
        logic [3:0]  ctl;   // {stall, flush_d, pc_src, ack}
        logic [31:0] tgt;
        logic [1:0]  rv;    // expected {imem_req, valid_d}
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] p8;
    } vec_t;
    vec_t tv [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: scoreboard check on the falling edge, then move to just past
    // the next rising edge where new inputs get driven.
    task automatic tick();
        logic [31:0] a;
        @(negedge clk);
        if (sb_on && valid_d && !stall && !reset) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra actual_inst=%h required=none", inst_d);
            end else begin
                a = sbq.pop_front();
                chk("sb_inst", inst_d, w(a));
                chk("sb_pc8", pc_plus8_d, a + 32'd8);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0; flush_d = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
        sb_on = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic done;
        total = 0; bad = 0;
        mem_auto = 1'b0; ack_man = 1'b0; wait_n = 0;

        tv[0]  = '{4'b0000, 32'h0,   2'b10, 32'h0,   32'h0,   32'h0,   32'h0};
        tv[1]  = '{4'b0001, 32'h0,   2'b10, 32'h0,   32'h0,   32'h0,   32'h0};
        tv[2]  = '{4'b1001, 32'h0,   2'b11, 32'h4,   32'h4,   w(32'h0), 32'h8};
        tv[3]  = '{4'b1000, 32'h0,   2'b01, 32'h0,   32'h4,   w(32'h0), 32'h8};
        tv[4]  = '{4'b0000, 32'h0,   2'b01, 32'h0,   32'h4,   w(32'h0), 32'h8};
        tv[5]  = '{4'b0000, 32'h0,   2'b11, 32'h8,   32'h8,   w(32'h4), 32'hC};
        tv[6]  = '{4'b0101, 32'h0,   2'b10, 32'h8,   32'h8,   w(32'h4), 32'hC};
        tv[7]  = '{4'b0001, 32'h0,   2'b10, 32'h8,   32'h8,   32'h0,   32'hC};
        tv[8]  = '{4'b0010, 32'h103, 2'b11, 32'hC,   32'hC,   w(32'h8), 32'h10};
        tv[9]  = '{4'b0000, 32'h0,   2'b10, 32'hC,   32'h100, 32'h0,   32'h0};
        tv[10] = '{4'b0010, 32'h183, 2'b10, 32'hC,   32'h100, 32'h0,   32'h0};
        tv[11] = '{4'b0001, 32'h0,   2'b10, 32'hC,   32'h180, 32'h0,   32'h0};
        tv[12] = '{4'b1001, 32'h0,   2'b10, 32'h180, 32'h180, 32'h0,   32'h0};
        tv[13] = '{4'b1010, 32'h203, 2'b00, 32'h0,   32'h180, 32'h0,   32'h0};
        tv[14] = '{4'b1000, 32'h0,   2'b10, 32'h200, 32'h200, 32'h0,   32'h0};
        tv[15] = '{4'b0001, 32'h0,   2'b10, 32'h200, 32'h200, 32'h0,   32'h0};
        tv[16] = '{4'b1000, 32'h0,   2'b11, 32'h204, 32'h204, w(32'h200), 32'h208};
        tv[17] = '{4'b0010, 32'hFFFF_FFFC, 2'b11, 32'h204, 32'h204, w(32'h200), 32'h208};
        tv[18] = '{4'b0001, 32'h0,   2'b10, 32'h204, 32'hFFFF_FFFC, 32'h0, 32'h0};
        tv[19] = '{4'b0001, 32'h0,   2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0};
        tv[20] = '{4'b0000, 32'h0,   2'b11, 32'h0,   32'h0,   w(32'hFFFF_FFFC), 32'h4};

        // Directed per-cycle table with a hand-driven ack.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            {stall, flush_d, pc_src, ack_man} = tv[i].ctl;
            branch_target = tv[i].tgt;
            @(negedge clk);
            chk($sformatf("tv%0d_req", i), {31'h0, imem_req}, {31'h0, tv[i].rv[1]});
            chk($sformatf("tv%0d_vld", i), {31'h0, valid_d}, {31'h0, tv[i].rv[0]});
            chk($sformatf("tv%0d_pc", i), pc_f, tv[i].pc);
            chk($sformatf("tv%0d_inst", i), inst_d, tv[i].inst);
            if (tv[i].rv[1]) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
            if (tv[i].rv[0]) chk($sformatf("tv%0d_pc8", i), pc_plus8_d, tv[i].p8);
            @(posedge clk);
            #1;
        end
        {stall, flush_d, pc_src, ack_man} = 4'b0000;

        // Zero-wait streaming, then a 3-cycle stall with the word at 0x10 parked.
        mem_auto = 1'b1; wait_n = 0;
        do_reset();
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_vld", {31'h0, valid_d}, 32'h0);
        for (int a = 0; a <= 32'h20; a += 4) sbq.push_back(a);
        sb_on = 1'b1;
        repeat (4) tick();
        chk("stream_pc", pc_f, 32'h10);
        chk("stream_rate", 32'(sbq.size()), 32'd6);
        stall = 1'b1;
        tick();
        chk("hold_req0", {31'h0, imem_req}, 32'h0);
        tick();
        chk("hold_req1", {31'h0, imem_req}, 32'h0);
        chk("hold_inst", inst_d, w(32'hC));
        tick();
        stall = 1'b0;
        chk("hold_req2", {31'h0, imem_req}, 32'h0);
        chk("hold_pc", pc_f, 32'h10);
        tick();
        chk("unhold_inst", inst_d, w(32'h10));
        chk("unhold_pc8", pc_plus8_d, 32'h18);
        chk("unhold_pc", pc_f, 32'h14);
        repeat (5) tick();
        sb_on = 1'b0;
        chk("stream_left", 32'(sbq.size()), 32'd0);

        // Two-wait memory, redirect while 0x20 is outstanding.
        wait_n = 2;
        do_reset();
        for (int a = 0; a < 32'h20; a += 4) sbq.push_back(a);
        sb_on = 1'b1;
        for (int k = 0; k < 100 && pc_f != 32'h20; k++) tick();
        chk("w2_reach20", pc_f, 32'h20);
        pc_src = 1'b1; branch_target = 32'h100;
        tick();
        pc_src = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            chk("drain_addr", imem_addr, 32'h20);
            chk("drain_req", {31'h0, imem_req}, 32'h1);
            chk("drain_vld", {31'h0, valid_d}, 32'h0);
            done = imem_ack;
            tick();
        end
        chk("drain_ack_seen", {31'h0, done}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_vld", {31'h0, valid_d}, 32'h0);
        chk("redir_q", 32'(sbq.size()), 32'd0);
        for (int a = 32'h100; a < 32'h110; a += 4) sbq.push_back(a);
        repeat (13) tick();
        sb_on = 1'b0;
        chk("w2_left", 32'(sbq.size()), 32'd0);

        // Asynchronous reset while a word sits in the skid buffer.
        wait_n = 0;
        do_reset();
        repeat (2) tick();
        stall = 1'b1;
        tick();
        chk("prer_req", {31'h0, imem_req}, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", pc_f, 32'h0);
        chk("arst_vld", {31'h0, valid_d}, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h1);
        stall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("post_addr", imem_addr, 32'h0);
        sbq.push_back(32'h0);
        sbq.push_back(32'h4);
        sb_on = 1'b1;
        repeat (3) tick();
        sb_on = 1'b0;
        chk("post_left", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
